// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl
// Measurement sequencer for the frequency-counter datapath. A start request
// flushes the datapath with a one-cycle clear pulse. A gate of exactly
// GATE_CYCLES clocks then opens, and rising edges of the synchronized input
// are counted during it. The latched count is offered on a valid/ready
// result port. Continuous mode re-arms the sequencer after each transfer.
//
// Parameters:
//   GATE_CYCLES  gate window length in clk cycles (>= 1)
//   COUNT_W      width of edge counter and result
//
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   synchronous active-high reset
//   start_i  in   start a measurement (sampled only in IDLE)
//   cont_i   in   continuous mode, sampled at result transfer
//   sig_i    in   signal under measurement, already synchronized to clk
//   ready_i  in   result consumer ready
//   clr_o    out  one-cycle datapath flush pulse
//   gate_o   out  high for the whole gate window
//   busy_o   out  high in every state except IDLE
//   valid_o  out  result valid
//   count_o  out  latched edge count
//   ovf_o    out  overflow flag (only when FREQ_GATE_OVF_EN is defined)
//
// Build option FREQ_GATE_OVF_EN: when defined, the edge counter saturates
// and a sticky overflow flag is reported on ovf_o. When undefined, the
// counter wraps and the ovf_o port is absent.

module freq_gate_ctrl #(
   parameter int GATE_CYCLES = 1000,
   parameter int COUNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic               cont_i,
   input  logic               sig_i,
   input  logic               ready_i,
   output logic               clr_o,
   output logic               gate_o,
   output logic               busy_o,
   output logic               valid_o,
`ifdef FREQ_GATE_OVF_EN
   output logic [COUNT_W-1:0] count_o,
   output logic               ovf_o
`else
   output logic [COUNT_W-1:0] count_o
`endif
);

   localparam int GCW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GCW-1:0] GATE_LAST = GCW'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_GATE  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t             state_r;
   logic [GCW-1:0]     gate_cnt_r;
   logic [COUNT_W-1:0] edge_cnt_r;
   logic               sig_q_r;
   logic               edge_s;
   logic [COUNT_W-1:0] cnt_nxt_s;

`ifdef FREQ_GATE_OVF_EN
   localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
   logic ovf_r;
   logic ovf_nxt_s;
`endif

   // Rising-edge detect and next edge-count value (wrap or saturate)
   always_comb begin
      edge_s    = 1'b0;
      cnt_nxt_s = edge_cnt_r;
`ifdef FREQ_GATE_OVF_EN
      ovf_nxt_s = ovf_r;
`endif
      if (state_r == ST_GATE) begin
         edge_s = sig_i & ~sig_q_r;
      end else begin
         edge_s = 1'b0;
      end
      if (edge_s) begin
`ifdef FREQ_GATE_OVF_EN
         if (edge_cnt_r == CNT_MAX) begin
            cnt_nxt_s = edge_cnt_r;
            ovf_nxt_s = 1'b1;
         end else begin
            cnt_nxt_s = edge_cnt_r + COUNT_W'(1);
            ovf_nxt_s = ovf_r;
         end
`else
         cnt_nxt_s = edge_cnt_r + COUNT_W'(1);
`endif
      end else begin
         cnt_nxt_s = edge_cnt_r;
      end
   end

   // Sequencer FSM with registered outputs and counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         gate_cnt_r <= '0;
         edge_cnt_r <= '0;
         sig_q_r    <= 1'b0;
         clr_o      <= 1'b0;
         gate_o     <= 1'b0;
         busy_o     <= 1'b0;
         valid_o    <= 1'b0;
         count_o    <= '0;
`ifdef FREQ_GATE_OVF_EN
         ovf_r      <= 1'b0;
         ovf_o      <= 1'b0;
`endif
      end else begin
         // sig_q also gets loaded in CLEAR, so a level already high at gate
         // open is not seen as an edge.
         sig_q_r <= sig_i;
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  state_r <= ST_CLEAR;
                  clr_o   <= 1'b1;
                  busy_o  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_CLEAR: begin
               state_r    <= ST_GATE;
               clr_o      <= 1'b0;
               gate_o     <= 1'b1;
               edge_cnt_r <= '0;
               gate_cnt_r <= '0;
`ifdef FREQ_GATE_OVF_EN
               ovf_r      <= 1'b0;
`endif
            end
            ST_GATE: begin
               edge_cnt_r <= cnt_nxt_s;
`ifdef FREQ_GATE_OVF_EN
               ovf_r      <= ovf_nxt_s;
`endif
               if (gate_cnt_r == GATE_LAST) begin
                  // Latch the next-value so an edge on the last gate cycle counts
                  state_r <= ST_HOLD;
                  gate_o  <= 1'b0;
                  valid_o <= 1'b1;
                  count_o <= cnt_nxt_s;
`ifdef FREQ_GATE_OVF_EN
                  ovf_o   <= ovf_nxt_s;
`endif
               end else begin
                  gate_cnt_r <= gate_cnt_r + GCW'(1);
               end
            end
            ST_HOLD: begin
               if (ready_i) begin
                  valid_o <= 1'b0;
                  if (cont_i) begin
                     state_r <= ST_CLEAR;
                     clr_o   <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                     busy_o  <= 1'b0;
                  end
               end else begin
                  state_r <= ST_HOLD;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               clr_o   <= 1'b0;
               gate_o  <= 1'b0;
               busy_o  <= 1'b0;
               valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
